// File: rtl/mux_scan_if.sv
// Handshake and mux-drive bundle between an upstream word source and the mux scan sequencer.
interface mux_scan_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] word;
    logic [2:0] sel;
    logic       bit_valid;
    logic       last;
    logic       done;
    logic [7:0] frame_cnt;

    modport master (
        output in_data, in_valid, flush,
        input  in_ready, word, sel, bit_valid, last, done, frame_cnt
    );

    modport slave (
        input  in_data, in_valid, flush,
        output in_ready, word, sel, bit_valid, last, done, frame_cnt
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Serializes one 8-bit word per handshake by stepping an 8:1 mux select across all positions,
// with optional inter-frame gap, flush, completion pulse and frame counter.
module mux_scan_sequencer #(
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_scan_if.slave  bus
);

    localparam int unsigned GAP_W      = 4;
    localparam logic [2:0]  SEL_FIRST  = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0]  SEL_FINAL  = MSB_FIRST ? 3'd0 : 3'd7;
    localparam bit          GAP_ZERO   = (GAP_CYCLES == 0);
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_ZERO ? GAP_W'(0) : GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [7:0]       word_q, word_d;
    logic [2:0]       sel_q, sel_d;
    logic             bit_valid_q, bit_valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic       in_ready_c;
    logic       accept;
    logic [2:0] sel_step;

    assign accept   = bus.in_valid && in_ready_c;
    assign sel_step = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides everything but reset
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) state_nxt = SHIFT;
                end
                SHIFT: begin
                    if (last_q) begin
                        if (!GAP_ZERO)   state_nxt = GAP;
                        else if (accept) state_nxt = SHIFT;
                        else             state_nxt = IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output logic: ready plus next values of the registered outputs
    always_comb begin
        in_ready_c  = 1'b0;
        word_d      = word_q;
        sel_d       = sel_q;
        bit_valid_d = bit_valid_q;
        last_d      = 1'b0;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        gap_cnt_d   = gap_cnt_q;

        case (state)
            IDLE:    in_ready_c = !bus.flush;
            SHIFT:   in_ready_c = last_q && GAP_ZERO && !bus.flush;
            default: in_ready_c = 1'b0;
        endcase

        if (bus.flush) begin
            bit_valid_d = 1'b0;
        end else begin
            if (state == SHIFT) begin
                if (last_q) begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    bit_valid_d = 1'b0;
                    gap_cnt_d   = '0;
                end else begin
                    sel_d  = sel_step;
                    last_d = (sel_step == SEL_FINAL);
                end
            end
            if (state == GAP) begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
            // A back-to-back accept in the last cycle restarts the frame without a bubble
            if (accept) begin
                word_d      = bus.in_data;
                sel_d       = SEL_FIRST;
                bit_valid_d = 1'b1;
                last_d      = 1'b0;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q      <= 8'h00;
            sel_q       <= 3'd0;
            bit_valid_q <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= 8'h00;
            gap_cnt_q   <= '0;
        end else begin
            word_q      <= word_d;
            sel_q       <= sel_d;
            bit_valid_q <= bit_valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.word      = word_q;
    assign bus.sel       = sel_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.last      = last_q;
    assign bus.done      = done_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule
